nibble_bus_sender: RTL

NIBBLE_BUS_SENDER -- requirements
Module: nibble_bus_sender

---
 rtl/nibble_bus_sender.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/nibble_bus_sender.sv
// ---------------------------------------------------------------------------
// nibble_bus_sender
//
// Sends one byte to a pair of downstream 4-bit registers over a shared 4-bit
// bus. The low nibble is sent first to the low-nibble register (nib_sel=0),
// and then the high nibble to the high-nibble register (nib_sel=1). Each
// nibble is held on the bus for HOLD_CYCLES setup cycles. A one-cycle load
// strobe (ei) follows, and the bus value does not change while it is high.
//
// Cycle timeline relative to the accepting clock edge (H = effective hold):
//   1..H        SETUP_LO   bus_oe=1, bus_out=byte[3:0], nib_sel=0
//   H+1         STROBE_LO  ei=1, low-nibble bus values held
//   H+2..2H+1   SETUP_HI   bus_oe=1, bus_out=byte[7:4], nib_sel=1
//   2H+2        STROBE_HI  ei=1, high-nibble bus values held
//   2H+3        DONE       done=1, bus idle
//
// Handshake: start is sampled on every rising clk edge. It is accepted only
// when the FSM is IDLE and the edge is not the first one after reset release.
// data is captured on that same edge. Any start seen outside IDLE is dropped
// and is not queued.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request to send one byte
//   data[7:0]  byte to send, captured on acceptance
//   bus_out    nibble toward the downstream register data input (0 when idle)
//   bus_oe     high while bus_out carries a valid nibble
//   ei         one-cycle load strobe for the downstream register enable
//   nib_sel    destination select: 0 = low register, 1 = high register
//   busy       high in every non-IDLE state
//   done       one-cycle pulse when the transfer completes
//   dbg_state  current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module nibble_bus_sender #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic [3:0] bus_out,
  output logic       bus_oe,
  output logic       ei,
  output logic       nib_sel,
  output logic       busy,
  output logic       done,
  output logic [2:0] dbg_state
);

  // A hold of 0 is treated as 1, so every nibble gets at least one setup cycle.
  localparam int         H_EFF  = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam logic [3:0] RELOAD = 4'(H_EFF - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP_LO  = 3'd1,
    S_STROBE_LO = 3'd2,
    S_SETUP_HI  = 3'd3,
    S_STROBE_HI = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [7:0] r_byte;
  logic [7:0] w_byte_nxt;
  // r_armed is cleared by reset and set on the first edge after release.
  // While it is low, start is ignored. A release that lands less than a cycle
  // before an edge can otherwise capture start while the flops leave reset.
  logic       r_armed;

  logic [3:0] r_bus_out;
  logic       r_bus_oe;
  logic       r_ei;
  logic       r_nib_sel;
  logic       r_busy;
  logic       r_done;

  logic [3:0] w_bus_out;
  logic       w_bus_oe;
  logic       w_ei;
  logic       w_nib_sel;
  logic       w_busy;
  logic       w_done;

  // Next-state logic. The counter holds the number of setup cycles still
  // remaining after the current one. It is reloaded on every entry to a SETUP
  // state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_byte_nxt  = r_byte;
    case (r_state)
      S_IDLE: begin
        if (start && r_armed) begin
          w_state_nxt = S_SETUP_LO;
          w_cnt_nxt   = RELOAD;
          w_byte_nxt  = data;
        end
      end
      S_SETUP_LO: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_STROBE_LO;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_STROBE_LO: begin
        w_state_nxt = S_SETUP_HI;
        w_cnt_nxt   = RELOAD;
      end
      S_SETUP_HI: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_STROBE_HI;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_STROBE_HI: w_state_nxt = S_DONE;
      S_DONE:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // The outputs are decoded from the next state and registered. Each output
  // therefore changes on the same edge as the state it belongs to.
  always_comb begin
    w_bus_out = 4'd0;
    w_bus_oe  = 1'b0;
    w_ei      = 1'b0;
    w_nib_sel = 1'b0;
    w_busy    = (w_state_nxt != S_IDLE);
    w_done    = 1'b0;
    case (w_state_nxt)
      S_SETUP_LO, S_STROBE_LO: begin
        w_bus_out = w_byte_nxt[3:0];
        w_bus_oe  = 1'b1;
        w_ei      = (w_state_nxt == S_STROBE_LO);
      end
      S_SETUP_HI, S_STROBE_HI: begin
        w_bus_out = w_byte_nxt[7:4];
        w_bus_oe  = 1'b1;
        w_nib_sel = 1'b1;
        w_ei      = (w_state_nxt == S_STROBE_HI);
      end
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_byte    <= 8'd0;
      r_armed   <= 1'b0;
      r_bus_out <= 4'd0;
      r_bus_oe  <= 1'b0;
      r_ei      <= 1'b0;
      r_nib_sel <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_byte    <= w_byte_nxt;
      r_armed   <= 1'b1;
      r_bus_out <= w_bus_out;
      r_bus_oe  <= w_bus_oe;
      r_ei      <= w_ei;
      r_nib_sel <= w_nib_sel;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  assign bus_out   = r_bus_out;
  assign bus_oe    = r_bus_oe;
  assign ei        = r_ei;
  assign nib_sel   = r_nib_sel;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule
